fp_op_arbiter: RTL and testbench

FP_OP_ARBITER -- requirements
Module: fp_op_arbiter

---
 rtl/fp_op_arbiter.sv | 127 ++++++++++++
 tb/tb_fp_op_arbiter.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_op_arbiter.sv
// Two-requester arbiter sharing one FP adder and one FP multiplier, with a
// reservation shift register that keeps completions from colliding on the result bus.
// Define FP_OP_ARBITER_ROUND_ROBIN_EN for round-robin arbitration; the default is fixed priority to req0.
module fp_op_arbiter #(
   parameter int ADD_LAT = 7,
   parameter int MUL_LAT = 5
) (
   input  logic        clk,
   input  logic        program_resetn,
   input  logic        req0,
   input  logic        req1,
   input  logic        op0,
   input  logic        op1,
   input  logic [31:0] a0,
   input  logic [31:0] b0,
   input  logic [31:0] a1,
   input  logic [31:0] b1,
   output logic        gnt0,
   output logic        gnt1,
   output logic        done0,
   output logic        done1,
   output logic [31:0] result,
   output logic [31:0] adder_data_a,
   output logic [31:0] adder_data_b,
   input  logic [31:0] adder_out,
   output logic [31:0] multiplier_data_a,
   output logic [31:0] multiplier_data_b,
   input  logic [31:0] multiplier_out,
   output logic        busy
);

   localparam int MAX_LAT  = (ADD_LAT > MUL_LAT) ? ADD_LAT : MUL_LAT;
   localparam int DEPTH    = MAX_LAT + 1;
   localparam int ADD_SLOT = ADD_LAT + 1;
   localparam int MUL_SLOT = MUL_LAT + 1;

   // Slot i describes the operation completing i cycles from now; slot 0 completes this cycle.
   logic [DEPTH-1:0] slot_valid_reg, slot_owner_reg, slot_op_reg;
   logic [DEPTH-1:0] slot_valid_next, slot_owner_next, slot_op_next;
   logic [DEPTH:0]   valid_ext;
   logic             last_gnt_reg;
   logic [31:0]      result_reg;

   logic        add_free, mul_free;
   logic        grantable0, grantable1, pick1;
   logic        gnt_any, gnt_op;
   logic [31:0] gnt_a, gnt_b;
   logic        done_any;

   // The slot a new grant claims is checked before this cycle's shift, hence index LAT+1;
   // the extra top bit is always free for the longest-latency unit.
   assign valid_ext = {1'b0, slot_valid_reg};
   assign add_free  = ~valid_ext[ADD_SLOT];
   assign mul_free  = ~valid_ext[MUL_SLOT];

   assign grantable0 = program_resetn & req0 & (op0 ? mul_free : add_free);
   assign grantable1 = program_resetn & req1 & (op1 ? mul_free : add_free);

`ifdef FP_OP_ARBITER_ROUND_ROBIN_EN
   assign pick1 = grantable1 & (~grantable0 | ~last_gnt_reg);
`else
   assign pick1 = grantable1 & ~grantable0;
`endif

   assign gnt1    = pick1;
   assign gnt0    = grantable0 & ~pick1;
   assign gnt_any = gnt0 | gnt1;
   assign gnt_op  = gnt1 ? op1 : op0;
   assign gnt_a   = gnt1 ? a1 : a0;
   assign gnt_b   = gnt1 ? b1 : b0;

   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
      logic shift_valid, shift_owner, shift_op, hit;
      if (gi == DEPTH - 1) begin : g_top
         assign shift_valid = 1'b0;
         assign shift_owner = 1'b0;
         assign shift_op    = 1'b0;
      end else begin : g_mid
         assign shift_valid = slot_valid_reg[gi+1];
         assign shift_owner = slot_owner_reg[gi+1];
         assign shift_op    = slot_op_reg[gi+1];
      end
      assign hit = gnt_any & (gnt_op ? (gi == MUL_LAT) : (gi == ADD_LAT));
      assign slot_valid_next[gi] = hit | shift_valid;
      assign slot_owner_next[gi] = hit ? gnt1 : shift_owner;
      assign slot_op_next[gi]    = hit ? gnt_op : shift_op;
   end

   assign done0    = slot_valid_reg[0] & ~slot_owner_reg[0];
   assign done1    = slot_valid_reg[0] & slot_owner_reg[0];
   assign done_any = slot_valid_reg[0];
   assign busy     = |slot_valid_reg;
   assign result   = done_any ? (slot_op_reg[0] ? multiplier_out : adder_out) : result_reg;

   always_ff @(posedge clk or negedge program_resetn) begin
      if (!program_resetn) begin
         slot_valid_reg    <= '0;
         slot_owner_reg    <= '0;
         slot_op_reg       <= '0;
         last_gnt_reg      <= 1'b1;
         result_reg        <= '0;
         adder_data_a      <= '0;
         adder_data_b      <= '0;
         multiplier_data_a <= '0;
         multiplier_data_b <= '0;
      end else begin
         slot_valid_reg <= slot_valid_next;
         slot_owner_reg <= slot_owner_next;
         slot_op_reg    <= slot_op_next;
         result_reg     <= result;
         if (gnt0) begin
            last_gnt_reg <= 1'b0;
         end else if (gnt1) begin
            last_gnt_reg <= 1'b1;
         end
         if (gnt_any && !gnt_op) begin
            adder_data_a <= gnt_a;
            adder_data_b <= gnt_b;
         end
         if (gnt_any && gnt_op) begin
            multiplier_data_a <= gnt_a;
            multiplier_data_b <= gnt_b;
         end
      end
   end

endmodule

// File: tb/tb_fp_op_arbiter.sv
// Directed testbench for fp_op_arbiter with pipelined stand-ins for the adder and multiplier IPs.
module tb_fp_op_arbiter;

   localparam int ADD_LAT = 7;
   localparam int MUL_LAT = 5;

   logic        clk = 1'b0;
   logic        program_resetn;
   logic        req0, req1, op0, op1;
   logic [31:0] a0, b0, a1, b1;
   logic        gnt0, gnt1, done0, done1, busy;
   logic [31:0] result;
   logic [31:0] adder_data_a, adder_data_b, adder_out;
   logic [31:0] multiplier_data_a, multiplier_data_b, multiplier_out;

   int n_checks = 0;
   int n_pass   = 0;

   fp_op_arbiter #(.ADD_LAT(ADD_LAT), .MUL_LAT(MUL_LAT)) dut (
      .clk(clk), .program_resetn(program_resetn),
      .req0(req0), .req1(req1), .op0(op0), .op1(op1),
      .a0(a0), .b0(b0), .a1(a1), .b1(b1),
      .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
      .result(result),
      .adder_data_a(adder_data_a), .adder_data_b(adder_data_b), .adder_out(adder_out),
      .multiplier_data_a(multiplier_data_a), .multiplier_data_b(multiplier_data_b),
      .multiplier_out(multiplier_out),
      .busy(busy)
   );

   always #5 clk = ~clk;

   // IP stand-ins: exact IEEE results for the directed float vectors, plain integer ops otherwise.
   function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
      if (a == 32'h3F800000 && b == 32'h40000000) return 32'h40400000;
      if (a == 32'h3F800000 && b == 32'h3F800000) return 32'h40000000;
      return a + b;
   endfunction

   function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
      if (a == 32'h40000000 && b == 32'h40400000) return 32'h40C00000;
      return a ^ b;
   endfunction

   logic [31:0] add_pipe [ADD_LAT];
   logic [31:0] mul_pipe [MUL_LAT];

   always @(posedge clk) begin
      add_pipe[0] <= fadd(adder_data_a, adder_data_b);
      for (int i = 1; i < ADD_LAT; i++) add_pipe[i] <= add_pipe[i-1];
      mul_pipe[0] <= fmul(multiplier_data_a, multiplier_data_b);
      for (int i = 1; i < MUL_LAT; i++) mul_pipe[i] <= mul_pipe[i-1];
   end

   assign adder_out      = add_pipe[ADD_LAT-1];
   assign multiplier_out = mul_pipe[MUL_LAT-1];

   always @(negedge clk) begin
      if (done0 | done1) $display("[%0t] done0=%0b done1=%0b result=%h", $time, done0, done1, result);
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Waits for the next completion; 'at' counts cycles after the grant cycle, -1 on timeout.
   task automatic wait_done(input int from, output int at, output logic [1:0] who,
                            output logic [31:0] res);
      int k;
      at = -1; who = 2'b00; res = '0; k = from;
      while (at < 0 && k <= 20) begin
         tick();
         @(negedge clk);
         if (done0 | done1) begin
            at = k; who = {done1, done0}; res = result;
         end
         k++;
      end
   endtask

   task automatic drain();
      int k;
      k = 0;
      while (busy && k < 20) begin
         tick();
         @(negedge clk);
         k++;
      end
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int at, d0, d1, ng, nbusy_low, n0, n1, nd, nboth;
      logic [1:0]  who;
      logic [31:0] res;
      logic [5:0]  g0, g1;

      program_resetn = 1'b0;
      req0 = 0; req1 = 0; op0 = 0; op1 = 0;
      a0 = '0; b0 = '0; a1 = '0; b1 = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_eq("rst_gnt",    32'({gnt1, gnt0}), 0);
      check_eq("rst_done",   32'({done1, done0}), 0);
      check_eq("rst_busy",   32'(busy), 0);
      check_eq("rst_result", result, 0);
      tick();
      program_resetn = 1'b1;
      tick();

      // single add from requester 0
      req0 = 1; op0 = 0; a0 = 32'h3F800000; b0 = 32'h40000000;
      @(negedge clk);
      check_eq("s1_gnt", 32'({gnt1, gnt0}), 32'b01);
      tick();
      req0 = 0;
      @(negedge clk);
      check_eq("s1_add_a", adder_data_a, 32'h3F800000);
      check_eq("s1_add_b", adder_data_b, 32'h40000000);
      check_eq("s1_busy",  32'(busy), 1);
      wait_done(2, at, who, res);
      check_eq("s1_latency", at, 8);
      check_eq("s1_owner",   32'(who), 32'b01);
      check_eq("s1_result",  res, 32'h40400000);
      tick();
      @(negedge clk);
      check_eq("s1_hold_done", 32'({done1, done0}), 0);
      check_eq("s1_hold_result", result, 32'h40400000);

      // single multiply from requester 1
      tick();
      req1 = 1; op1 = 1; a1 = 32'h40000000; b1 = 32'h40400000;
      @(negedge clk);
      check_eq("s2_gnt", 32'({gnt1, gnt0}), 32'b10);
      tick();
      req1 = 0;
      @(negedge clk);
      check_eq("s2_mul_a", multiplier_data_a, 32'h40000000);
      check_eq("s2_mul_b", multiplier_data_b, 32'h40400000);
      check_eq("s2_add_hold", adder_data_a, 32'h3F800000);
      wait_done(2, at, who, res);
      check_eq("s2_latency", at, 6);
      check_eq("s2_owner",   32'(who), 32'b10);
      check_eq("s2_result",  res, 32'h40C00000);

      // mul requested two cycles after an add would collide on the same completion slot
      tick();
      req0 = 1; op0 = 0; a0 = 32'h3F800000; b0 = 32'h3F800000;
      @(negedge clk);
      check_eq("s3_gnt0", 32'(gnt0), 1);
      tick();
      req0 = 0;
      tick();
      req1 = 1; op1 = 1; a1 = 32'h40000000; b1 = 32'h40400000;
      @(negedge clk);
      check_eq("s3_withheld", 32'(gnt1), 0);
      tick();
      @(negedge clk);
      check_eq("s3_gnt1", 32'(gnt1), 1);
      d0 = -1; d1 = -1; nboth = 0;
      for (int j = 4; j <= 14; j++) begin
         tick();
         req1 = 0;
         @(negedge clk);
         if (done0 && done1) nboth++;
         if (done0) begin
            d0 = j;
            check_eq("s3_add_result", result, 32'h40000000);
         end
         if (done1) begin
            d1 = j;
            check_eq("s3_mul_result", result, 32'h40C00000);
         end
      end
      check_eq("s3_add_done", d0, 8);
      check_eq("s3_mul_done", d1, 9);
      check_eq("s3_no_overlap", nboth, 0);
      drain();

      // both requesters hold add requests
      g0 = '0; g1 = '0; nboth = 0;
      for (int j = 0; j < 6; j++) begin
         if (j > 0) tick();
         req0 = 1; op0 = 0; a0 = 32'h10 + j; b0 = 32'h20;
         req1 = 1; op1 = 0; a1 = 32'h30 + j; b1 = 32'h40;
         @(negedge clk);
         g0[j] = gnt0; g1[j] = gnt1;
         if (gnt0 && gnt1) nboth++;
      end
      tick();
      req0 = 0; req1 = 0;
      n0 = 0; n1 = 0;
      for (int j = 0; j < 12; j++) begin
         @(negedge clk);
         if (done0) n0++;
         if (done1) n1++;
         tick();
      end
`ifdef FP_OP_ARBITER_ROUND_ROBIN_EN
      check_eq("s4_gnt0_pattern", 32'(g0), 32'b010101);
      check_eq("s4_gnt1_pattern", 32'(g1), 32'b101010);
      check_eq("s4_done0_count", n0, 3);
      check_eq("s4_done1_count", n1, 3);
`else
      check_eq("s4_gnt0_pattern", 32'(g0), 32'b111111);
      check_eq("s4_gnt1_pattern", 32'(g1), 32'b000000);
      check_eq("s4_done0_count", n0, 6);
      check_eq("s4_done1_count", n1, 0);
`endif
      check_eq("s4_one_grant", nboth, 0);
      drain();

      // back-to-back adds from requester 0
      ng = 0; nbusy_low = 0;
      for (int j = 0; j < 20; j++) begin
         if (j > 0) tick();
         if (j < 10) begin
            req0 = 1; op0 = 0; a0 = 32'h100 + j; b0 = 32'h1000;
         end else begin
            req0 = 0;
         end
         @(negedge clk);
         if (j < 10 && gnt0) ng++;
         if (j >= 1 && j <= 17 && !busy) nbusy_low++;
         if (j >= 8 && j <= 17) begin
            check_eq("s5_done0", 32'(done0), 1);
            check_eq("s5_result", result, 32'h1100 + (j - 8));
         end
         if (j == 18) begin
            check_eq("s5_tail_done0", 32'(done0), 0);
            check_eq("s5_tail_busy",  32'(busy), 0);
         end
      end
      check_eq("s5_grants", ng, 10);
      check_eq("s5_busy_gaps", nbusy_low, 0);
      drain();

      // reset three cycles after a multiply grant
      req1 = 1; op1 = 1; a1 = 32'h40000000; b1 = 32'h40400000;
      @(negedge clk);
      check_eq("s6_gnt1", 32'(gnt1), 1);
      tick();
      req1 = 0;
      tick();
      tick();
      program_resetn = 1'b0;
      req0 = 1; op0 = 0; a0 = 32'h1; b0 = 32'h2;
      @(negedge clk);
      check_eq("s6_rst_gnt",    32'({gnt1, gnt0}), 0);
      check_eq("s6_rst_done",   32'({done1, done0}), 0);
      check_eq("s6_rst_busy",   32'(busy), 0);
      check_eq("s6_rst_result", result, 0);
      check_eq("s6_rst_add_a",  adder_data_a, 0);
      check_eq("s6_rst_add_b",  adder_data_b, 0);
      check_eq("s6_rst_mul_a",  multiplier_data_a, 0);
      check_eq("s6_rst_mul_b",  multiplier_data_b, 0);
      tick();
      tick();
      program_resetn = 1'b1;
      req0 = 0;
      nd = 0; nbusy_low = 0;
      for (int j = 0; j < 10; j++) begin
         @(negedge clk);
         if (done0 | done1) nd++;
         if (busy) nbusy_low++;
         tick();
      end
      check_eq("s6_no_done", nd, 0);
      check_eq("s6_idle", nbusy_low, 0);
      req0 = 1; op0 = 0; a0 = 32'h5; b0 = 32'h6;
      req1 = 1; op1 = 0; a1 = 32'h7; b1 = 32'h8;
      @(negedge clk);
      check_eq("s6_first_winner", 32'({gnt1, gnt0}), 32'b01);
      tick();
      req0 = 0; req1 = 0;
      tick();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
